// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and shared-ALU signals between two requesters,
// the alu_arbiter and an external combinational ALU.
interface alu_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [5:0]         req_op;
  logic [2*WIDTH-1:0] req_x;
  logic [2*WIDTH-1:0] req_y;
  logic [1:0]         req_cin;

  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_s;
  logic               rsp_c;
  logic               rsp_zero;
  logic               rsp_of;

  logic [2:0]         alu_op;
  logic               alu_in_c;
  logic [WIDTH-1:0]   alu_in_x;
  logic [WIDTH-1:0]   alu_in_y;
  logic [WIDTH-1:0]   alu_out_s;
  logic               alu_out_c;
  logic               alu_zero;
  logic               alu_overflow;

  // Requesters plus the shared ALU.
  modport master (
    output req_valid, req_op, req_x, req_y, req_cin, rsp_ready,
    output alu_out_s, alu_out_c, alu_zero, alu_overflow,
    input  req_ready, rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_of,
    input  alu_op, alu_in_c, alu_in_x, alu_in_y
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_op, req_x, req_y, req_cin, rsp_ready,
    input  alu_out_s, alu_out_c, alu_zero, alu_overflow,
    output req_ready, rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_of,
    output alu_op, alu_in_c, alu_in_x, alu_in_y
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to requester 0.
module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg, last_grant_next;
  logic             grant_reg, grant_next;
  logic [2:0]       op_reg, op_next;
  logic             cin_reg, cin_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [WIDTH-1:0] rsp_s_reg, rsp_s_next;
  logic             rsp_c_reg, rsp_c_next;
  logic             rsp_zero_reg, rsp_zero_next;
  logic             rsp_of_reg, rsp_of_next;

  logic [2:0]       op_arr [2];
  logic [WIDTH-1:0] x_arr  [2];
  logic [WIDTH-1:0] y_arr  [2];
  logic             winner;
  logic             accept;
  logic             handshake;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign op_arr[gi]        = bus.req_op[gi*3 +: 3];
      assign x_arr[gi]         = bus.req_x[gi*WIDTH +: WIDTH];
      assign y_arr[gi]         = bus.req_y[gi*WIDTH +: WIDTH];
      assign bus.req_ready[gi] = accept && (winner == 1'(gi));
      assign bus.rsp_valid[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
    end
  endgenerate

  // Winner is only meaningful when at least one request is valid.
  always_comb begin
    winner = !bus.req_valid[0] && bus.req_valid[1];
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (&bus.req_valid) begin
      winner = ~last_grant_reg;
    end
`endif
  end

  // req_ready is gated by rst_n so nothing is accepted during reset.
  assign accept    = (state_reg == IDLE) && rst_n && (|bus.req_valid);
  assign handshake = (state_reg == RESP) && bus.rsp_ready[grant_reg];

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    op_next         = op_reg;
    cin_next        = cin_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    rsp_s_next      = rsp_s_reg;
    rsp_c_next      = rsp_c_reg;
    rsp_zero_next   = rsp_zero_reg;
    rsp_of_next     = rsp_of_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          grant_next = winner;
          op_next    = op_arr[winner];
          x_next     = x_arr[winner];
          y_next     = y_arr[winner];
          cin_next   = bus.req_cin[winner];
          state_next = EXEC;
        end
      end
      EXEC: begin
        rsp_s_next    = bus.alu_out_s;
        rsp_c_next    = bus.alu_out_c;
        rsp_zero_next = bus.alu_zero;
        rsp_of_next   = bus.alu_overflow;
        state_next    = RESP;
      end
      RESP: begin
        if (handshake) begin
          last_grant_next = grant_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      op_reg         <= '0;
      cin_reg        <= 1'b0;
      x_reg          <= '0;
      y_reg          <= '0;
      rsp_s_reg      <= '0;
      rsp_c_reg      <= 1'b0;
      rsp_zero_reg   <= 1'b0;
      rsp_of_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      op_reg         <= op_next;
      cin_reg        <= cin_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      rsp_s_reg      <= rsp_s_next;
      rsp_c_reg      <= rsp_c_next;
      rsp_zero_reg   <= rsp_zero_next;
      rsp_of_reg     <= rsp_of_next;
    end
  end

  assign bus.alu_op   = op_reg;
  assign bus.alu_in_c = cin_reg;
  assign bus.alu_in_x = x_reg;
  assign bus.alu_in_y = y_reg;
  assign bus.rsp_s    = rsp_s_reg;
  assign bus.rsp_c    = rsp_c_reg;
  assign bus.rsp_zero = rsp_zero_reg;
  assign bus.rsp_of   = rsp_of_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; models the external ALU as
// op 0 = add with carry-in, any other op = bitwise AND.
module tb_alu_arbiter;
  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [WIDTH:0] alu_sum;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_sum = {1'b0, bus.alu_in_x} + {1'b0, bus.alu_in_y} + {{WIDTH{1'b0}}, bus.alu_in_c};
    if (bus.alu_op == 3'd0) begin
      bus.alu_out_s    = alu_sum[WIDTH-1:0];
      bus.alu_out_c    = alu_sum[WIDTH];
      bus.alu_overflow = (bus.alu_in_x[WIDTH-1] == bus.alu_in_y[WIDTH-1]) &&
                         (alu_sum[WIDTH-1] != bus.alu_in_x[WIDTH-1]);
    end else begin
      bus.alu_out_s    = bus.alu_in_x & bus.alu_in_y;
      bus.alu_out_c    = 1'b0;
      bus.alu_overflow = 1'b0;
    end
    bus.alu_zero = (bus.alu_out_s == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    tick();
    tick();
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b expected 00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 00", bus.rsp_valid); end
    checks++; if (bus.rsp_s !== 4'h0) begin errors++; $display("FAIL rst_rsp_s: got %h expected 0", bus.rsp_s); end
    checks++; if ({bus.alu_op, bus.alu_in_c, bus.alu_in_x, bus.alu_in_y} !== 12'h000) begin errors++; $display("FAIL rst_alu_inputs: got %h expected 000", {bus.alu_op, bus.alu_in_c, bus.alu_in_x, bus.alu_in_y}); end
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_req0();
    bus.req_op = 6'o00; bus.req_x = 8'h01; bus.req_y = 8'h01; bus.req_cin = 2'b00;
    bus.req_valid = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL r0_req_ready: got %b expected 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    checks++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL r0_exec_idle_outs: got ready=%b valid=%b expected 00/00", bus.req_ready, bus.rsp_valid); end
    checks++; if ({bus.alu_in_x, bus.alu_in_y} !== 8'h11) begin errors++; $display("FAIL r0_alu_in: got %h expected 11", {bus.alu_in_x, bus.alu_in_y}); end
    tick();
    checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL r0_rsp_valid: got %b expected 01", bus.rsp_valid); end
    checks++; if ({bus.rsp_s, bus.rsp_c, bus.rsp_zero, bus.rsp_of} !== 7'b0010_000) begin errors++; $display("FAIL r0_result: got %b expected 0010000", {bus.rsp_s, bus.rsp_c, bus.rsp_zero, bus.rsp_of}); end
    $display("txn req0 add: s=%h c=%b z=%b of=%b", bus.rsp_s, bus.rsp_c, bus.rsp_zero, bus.rsp_of);
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL r0_after_hs_valid: got %b expected 00", bus.rsp_valid); end
    checks++; if (bus.rsp_s !== 4'h2) begin errors++; $display("FAIL r0_rsp_persist: got %h expected 2", bus.rsp_s); end
  endtask

  task automatic test_single_req1();
    bus.req_op = 6'o00; bus.req_x = 8'h30; bus.req_y = 8'hD0; bus.req_cin = 2'b00;
    bus.req_valid = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL r1_req_ready: got %b expected 10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    tick();
    checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("FAIL r1_rsp_valid: got %b expected 10", bus.rsp_valid); end
    checks++; if ({bus.rsp_s, bus.rsp_c, bus.rsp_zero, bus.rsp_of} !== 7'b0000_110) begin errors++; $display("FAIL r1_result: got %b expected 0000110", {bus.rsp_s, bus.rsp_c, bus.rsp_zero, bus.rsp_of}); end
    bus.rsp_ready = 2'b01;
    tick();
    checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("FAIL r1_ignore_other_ready: got %b expected 10", bus.rsp_valid); end
    bus.rsp_ready = 2'b10;
    $display("txn req1 add: s=%h c=%b z=%b of=%b", bus.rsp_s, bus.rsp_c, bus.rsp_zero, bus.rsp_of);
    tick();
    bus.rsp_ready = 2'b00;
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL r1_after_hs_valid: got %b expected 00", bus.rsp_valid); end
  endtask

  task automatic test_tie();
    logic [1:0] exp_second;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_second = 2'b10;
`else
    exp_second = 2'b01;
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_op = 6'o00; bus.req_x = 8'h77; bus.req_y = 8'h11; bus.req_cin = 2'b00;
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL tie_first_ready: got %b expected 01", bus.req_ready); end
    tick();
    tick();
    checks++; if (bus.rsp_valid !== 2'b01 || bus.req_ready !== 2'b00) begin errors++; $display("FAIL tie_first_rsp: got valid=%b ready=%b expected 01/00", bus.rsp_valid, bus.req_ready); end
    checks++; if ({bus.rsp_s, bus.rsp_c, bus.rsp_zero, bus.rsp_of} !== 7'b1000_001) begin errors++; $display("FAIL tie_first_result: got %b expected 1000001", {bus.rsp_s, bus.rsp_c, bus.rsp_zero, bus.rsp_of}); end
    $display("txn tie first: rsp_valid=%b s=%h of=%b", bus.rsp_valid, bus.rsp_s, bus.rsp_of);
    bus.rsp_ready = 2'b11;
    tick();
    checks++; if (bus.req_ready !== exp_second) begin errors++; $display("FAIL tie_second_ready: got %b expected %b", bus.req_ready, exp_second); end
    tick();
    bus.req_valid = 2'b00;
    tick();
    checks++; if (bus.rsp_valid !== exp_second) begin errors++; $display("FAIL tie_second_rsp: got %b expected %b", bus.rsp_valid, exp_second); end
    checks++; if ({bus.rsp_s, bus.rsp_of} !== 5'b1000_1) begin errors++; $display("FAIL tie_second_result: got %b expected 10001", {bus.rsp_s, bus.rsp_of}); end
    $display("txn tie second: rsp_valid=%b s=%h of=%b", bus.rsp_valid, bus.rsp_s, bus.rsp_of);
    tick();
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    bus.req_op = 6'o00; bus.req_x = 8'h05; bus.req_y = 8'h02; bus.req_cin = 2'b01;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b10;
    checks++; if (bus.alu_in_c !== 1'b1) begin errors++; $display("FAIL bp_alu_in_c: got %b expected 1", bus.alu_in_c); end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_s !== 4'h8 || bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_hold_%0d: got valid=%b s=%h ready=%b expected 01/8/00", i, bus.rsp_valid, bus.rsp_s, bus.req_ready); end
      tick();
    end
    checks++; if ({bus.rsp_c, bus.rsp_zero, bus.rsp_of} !== 3'b001) begin errors++; $display("FAIL bp_flags: got %b expected 001", {bus.rsp_c, bus.rsp_zero, bus.rsp_of}); end
    $display("txn req0 add cin: s=%h c=%b z=%b of=%b", bus.rsp_s, bus.rsp_c, bus.rsp_zero, bus.rsp_of);
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;
    checks++; if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 00/10", bus.rsp_valid, bus.req_ready); end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_in_resp();
    bus.req_op = 6'o23; bus.req_x = 8'h5C; bus.req_y = 8'h3A; bus.req_cin = 2'b00;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    tick();
    checks++; if (bus.rsp_valid !== 2'b01 || bus.alu_op !== 3'd3) begin errors++; $display("FAIL rr_pre: got valid=%b op=%0d expected 01/3", bus.rsp_valid, bus.alu_op); end
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    tick();
    checks++; if (bus.rsp_valid !== 2'b00 || bus.rsp_s !== 4'h0 || bus.alu_op !== 3'd0) begin errors++; $display("FAIL rr_abort: got valid=%b s=%h op=%0d expected 00/0/0", bus.rsp_valid, bus.rsp_s, bus.alu_op); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rr_ready_in_reset: got %b expected 00", bus.req_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rr_rearb: got %b expected 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    tick();
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_s !== 4'h8 || bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL rr_and_result: got valid=%b s=%h z=%b expected 01/8/0", bus.rsp_valid, bus.rsp_s, bus.rsp_zero); end
    $display("txn req0 and: s=%h z=%b", bus.rsp_s, bus.rsp_zero);
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_op = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_cin = '0;
    bus.rsp_ready = 2'b00;
    test_reset();
    test_single_req0();
    test_single_req1();
    test_tie();
    test_backpressure();
    test_reset_in_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
